// File: rtl/audio_tone_gen.sv
// Test-tone source: phase accumulator -> waveform shaper -> volume scaler -> L/R output stage.
// Latency: ack sampled at edge T, new audio_l/audio_r visible after edge T+3, held until next update.
// Backpressure: none; every ack produces exactly one in-order update, back-to-back acks included.
module audio_tone_gen #(
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ack,
    input  logic               sync,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic [1:0]         cfg_wave,
    input  logic [7:0]         cfg_vol,
    input  logic               cfg_inv_r,
    output logic [23:0]        audio_l,
    output logic [23:0]        audio_r
);

    localparam logic [1:0] WAVE_OFF    = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_SAW    = 2'd2;
    localparam logic [1:0] WAVE_TRI    = 2'd3;

    // Stage 0: phase and config snapshot taken on ack
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [1:0]         wave0_q, wave0_d;
    logic [7:0]         vol0_q, vol0_d;
    logic               inv0_q, inv0_d;

    // Stage 1: shaped sample plus the config still needed downstream
    logic [15:0]        s_q, s_d;
    logic [7:0]         vol1_q, vol1_d;
    logic               inv1_q, inv1_d;

    // Stage 2: scaled sample
    logic [15:0]        y_q, y_d;
    logic               inv2_q, inv2_d;

    // Stage 3: output registers
    logic [23:0]        audio_l_q, audio_l_d;
    logic [23:0]        audio_r_q, audio_r_d;

    // Pipeline valid bits: shift of ack
    logic [2:0]         vld_q, vld_d;

    // Combinational helpers
    logic [15:0]        p;
    logic [14:0]        tri_u;
    logic [15:0]        shp;
    logic signed [23:0] prod;
    logic [15:0]        y_neg;

    // Shaper, scaler and output formatting; config travels alongside its sample
    always_comb begin
        phase_d   = phase_q;
        wave0_d   = wave0_q;
        vol0_d    = vol0_q;
        inv0_d    = inv0_q;
        s_d       = s_q;
        vol1_d    = vol1_q;
        inv1_d    = inv1_q;
        y_d       = y_q;
        inv2_d    = inv2_q;
        audio_l_d = audio_l_q;
        audio_r_d = audio_r_q;
        vld_d     = {vld_q[1:0], ack};

        // Stage 0: sync wins over the increment; sync alone only clears phase
        if (ack) begin
            phase_d = sync ? '0 : phase_q + cfg_inc;
            wave0_d = cfg_wave;
            vol0_d  = cfg_vol;
            inv0_d  = cfg_inv_r;
        end else if (sync) begin
            phase_d = '0;
        end

        // Stage 1: waveform from the top 16 phase bits
        p     = 16'(phase_q >> (PHASE_W - 16));
        tri_u = p[15] ? ~p[14:0] : p[14:0];
        unique case (wave0_q)
            WAVE_OFF:    shp = 16'h0000;
            WAVE_SQUARE: shp = p[15] ? 16'h8000 : 16'h7FFF;
            WAVE_SAW:    shp = p ^ 16'h8000;
            WAVE_TRI:    shp = {tri_u, 1'b0} ^ 16'h8000;
            default:     shp = 16'h0000;
        endcase
        if (vld_q[0]) begin
            s_d    = shp;
            vol1_d = vol0_q;
            inv1_d = inv0_q;
        end

        // Stage 2: signed sample times unsigned gain, floor divide by 256.
        // |product| <= 32768*255 so 24 signed bits hold it exactly.
        prod = $signed(s_q) * $signed({1'b0, vol1_q});
        if (vld_q[1]) begin
            y_d    = 16'(prod >>> 8);
            inv2_d = inv1_q;
        end

        // Stage 3: right channel optionally negated, -32768 saturates to +32767
        y_neg = (y_q == 16'h8000) ? 16'h7FFF : 16'(-y_q);
        if (vld_q[2]) begin
            audio_l_d = {y_q, 8'h00};
            audio_r_d = inv2_q ? {y_neg, 8'h00} : {y_q, 8'h00};
        end
    end

    // State registers; async reset also flushes any sample mid-pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= '0;
            wave0_q   <= WAVE_OFF;
            vol0_q    <= '0;
            inv0_q    <= 1'b0;
            s_q       <= '0;
            vol1_q    <= '0;
            inv1_q    <= 1'b0;
            y_q       <= '0;
            inv2_q    <= 1'b0;
            audio_l_q <= '0;
            audio_r_q <= '0;
            vld_q     <= '0;
        end else begin
            phase_q   <= phase_d;
            wave0_q   <= wave0_d;
            vol0_q    <= vol0_d;
            inv0_q    <= inv0_d;
            s_q       <= s_d;
            vol1_q    <= vol1_d;
            inv1_q    <= inv1_d;
            y_q       <= y_d;
            inv2_q    <= inv2_d;
            audio_l_q <= audio_l_d;
            audio_r_q <= audio_r_d;
            vld_q     <= vld_d;
        end
    end

    assign audio_l = audio_l_q;
    assign audio_r = audio_r_q;

    // With an 8-bit gain the scaler can never produce -32768; the saturating
    // negate above only guards against a future wider gain.
    always @(posedge clk) begin
        if (rst_n && vld_q[1]) begin
            assert (y_d != 16'h8000);
        end
    end

endmodule

// File: tb/tb_audio_tone_gen.sv
// Directed bench for audio_tone_gen: reset, each waveform, volume, inversion, sync, back-to-back, mid-flight reset.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
// Expected values are hand-computed from the waveform/gain arithmetic.
module tb_audio_tone_gen;

    logic        clk;
    logic        rst_n;
    logic        ack;
    logic        sync;
    logic [15:0] cfg_inc;
    logic [1:0]  cfg_wave;
    logic [7:0]  cfg_vol;
    logic        cfg_inv_r;
    logic [23:0] audio_l;
    logic [23:0] audio_r;

    int errors = 0;
    int checks = 0;

    audio_tone_gen #(.PHASE_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ack       (ack),
        .sync      (sync),
        .cfg_inc   (cfg_inc),
        .cfg_wave  (cfg_wave),
        .cfg_vol   (cfg_vol),
        .cfg_inv_r (cfg_inv_r),
        .audio_l   (audio_l),
        .audio_r   (audio_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One ack pulse with the given config; config is scrambled afterwards to
    // prove that only the snapshot taken on ack is used. Returns on the falling
    // edge right after the sampling edge T.
    task automatic do_ack(input logic [15:0] inc, input logic [1:0] wave,
                          input logic [7:0] vol, input logic inv, input logic sy);
        @(negedge clk);
        cfg_inc   = inc;
        cfg_wave  = wave;
        cfg_vol   = vol;
        cfg_inv_r = inv;
        ack       = 1'b1;
        sync      = sy;
        @(negedge clk);
        ack       = 1'b0;
        sync      = 1'b0;
        cfg_inc   = 16'hFFFF;
        cfg_wave  = 2'd0;
        cfg_vol   = 8'h00;
        cfg_inv_r = ~inv;
    endtask

    task automatic sync_only();
        @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (audio_l !== 24'h0 || audio_r !== 24'h0) begin
            errors++;
            $display("FAIL reset_in: got L=%h R=%h want 0/0", audio_l, audio_r);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (audio_l !== 24'h0 || audio_r !== 24'h0) begin
            errors++;
            $display("FAIL reset_after: got L=%h R=%h want 0/0", audio_l, audio_r);
        end
    endtask

    task automatic test_sawtooth();
        do_ack(16'h0400, 2'd2, 8'd255, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (audio_l !== 24'h0) begin
            errors++;
            $display("FAIL saw_latency: got L=%h before T+3 want 000000", audio_l);
        end
        @(negedge clk);
        checks++;
        if (audio_l !== 24'h847C00 || audio_r !== 24'h847C00) begin
            errors++;
            $display("FAIL saw_vol255: got L=%h R=%h want 847c00/847c00", audio_l, audio_r);
        end
        do_ack(16'h0400, 2'd2, 8'h80, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (audio_l !== 24'hC40000 || audio_r !== 24'hC40000) begin
            errors++;
            $display("FAIL saw_vol80: got L=%h R=%h want c40000/c40000", audio_l, audio_r);
        end
    endtask

    task automatic test_triangle();
        logic [23:0] exp_tri [4];
        exp_tri[0] = 24'h000000;   // phase 0x4000
        exp_tri[1] = 24'h7F7E00;   // phase 0x8000: floor(32766*255/256) = 32638
        exp_tri[2] = 24'hFFFE00;   // phase 0xC000: floor(-2*255/256) = -2
        exp_tri[3] = 24'h808000;   // phase wrapped to 0x0000: -32640
        sync_only();
        for (int i = 0; i < 4; i++) begin
            do_ack(16'h4000, 2'd3, 8'd255, 1'b0, 1'b0);
            repeat (3) @(negedge clk);
            checks++;
            if (audio_l !== exp_tri[i] || audio_r !== exp_tri[i]) begin
                errors++;
                $display("FAIL tri_%0d: got L=%h R=%h want %h", i, audio_l, audio_r, exp_tri[i]);
            end
        end
    endtask

    task automatic test_square();
        // phase 0 -> 0x8000, vol 0
        do_ack(16'h8000, 2'd1, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (audio_l !== 24'h0 || audio_r !== 24'h0) begin
            errors++;
            $display("FAIL sq_vol0: got L=%h R=%h want 0/0", audio_l, audio_r);
        end
        // phase stays 0x8000: s=-32768 -> y=-32640, R=+32640
        do_ack(16'h0000, 2'd1, 8'd255, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (audio_l !== 24'h808000 || audio_r !== 24'h7F8000) begin
            errors++;
            $display("FAIL sq_inv_neg: got L=%h R=%h want 808000/7f8000", audio_l, audio_r);
        end
        // phase wraps to 0: s=32767 -> y=32639, R=-32639
        do_ack(16'h8000, 2'd1, 8'd255, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (audio_l !== 24'h7F7F00 || audio_r !== 24'h808100) begin
            errors++;
            $display("FAIL sq_inv_pos: got L=%h R=%h want 7f7f00/808100", audio_l, audio_r);
        end
    endtask

    task automatic test_sync();
        // phase 0 -> 0x3000: s=0xB000 -> y=-20400
        do_ack(16'h3000, 2'd2, 8'd255, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (audio_l !== 24'hB05000) begin
            errors++;
            $display("FAIL sync_pre: got L=%h want b05000", audio_l);
        end
        // ack+sync: phase forced to 0 instead of 0x6000
        do_ack(16'h3000, 2'd2, 8'd255, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (audio_l !== 24'h808000 || audio_r !== 24'h808000) begin
            errors++;
            $display("FAIL sync_ack: got L=%h R=%h want 808000/808000", audio_l, audio_r);
        end
        do_ack(16'h1000, 2'd2, 8'd255, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (audio_l !== 24'h907000) begin
            errors++;
            $display("FAIL sync_step: got L=%h want 907000", audio_l);
        end
        // sync alone: no output update
        sync_only();
        repeat (5) @(negedge clk);
        checks++;
        if (audio_l !== 24'h907000 || audio_r !== 24'h907000) begin
            errors++;
            $display("FAIL sync_alone_hold: got L=%h R=%h want 907000/907000", audio_l, audio_r);
        end
        // phase was cleared, so next step lands on 0x1000 again (not 0x2000 -> a06000)
        do_ack(16'h1000, 2'd2, 8'd255, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (audio_l !== 24'h907000) begin
            errors++;
            $display("FAIL sync_alone_clear: got L=%h want 907000", audio_l);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  vols [3];
        logic [23:0] exp_b [3];
        vols[0] = 8'h80; exp_b[0] = 24'hC00000;
        vols[1] = 8'h40; exp_b[1] = 24'hE00000;
        vols[2] = 8'h20; exp_b[2] = 24'hF00000;
        sync_only();
        @(negedge clk);
        cfg_inc   = 16'h0000;
        cfg_wave  = 2'd2;
        cfg_inv_r = 1'b0;
        ack       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cfg_vol = vols[i];
            @(negedge clk);
        end
        ack     = 1'b0;
        cfg_vol = 8'h00;
        checks++;
        if (audio_l !== 24'h907000) begin
            errors++;
            $display("FAIL b2b_early: got L=%h want 907000", audio_l);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (audio_l !== exp_b[i] || audio_r !== exp_b[i]) begin
                errors++;
                $display("FAIL b2b_%0d: got L=%h R=%h want %h", i, audio_l, audio_r, exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        cfg_inc   = 16'h0000;
        cfg_wave  = 2'd2;
        cfg_vol   = 8'd255;
        cfg_inv_r = 1'b0;
        ack       = 1'b1;
        @(negedge clk);
        ack   = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (audio_l !== 24'h0 || audio_r !== 24'h0) begin
            errors++;
            $display("FAIL rst_async: got L=%h R=%h want 0/0", audio_l, audio_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (audio_l !== 24'h0 || audio_r !== 24'h0) begin
                errors++;
                $display("FAIL rst_flush_%0d: got L=%h R=%h want 0/0", i, audio_l, audio_r);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ack       = 1'b0;
        sync      = 1'b0;
        cfg_inc   = 16'h0000;
        cfg_wave  = 2'd0;
        cfg_vol   = 8'h00;
        cfg_inv_r = 1'b0;
        test_reset();
        test_sawtooth();
        test_triangle();
        test_square();
        test_sync();
        test_back_to_back();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
